// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared FSM encoding, status-register layout and reset values for spi_master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_master_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  // Control/status register bit positions
  localparam int STAT_BUSY     = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_TX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_RX_FULL  = 4;
  localparam int STAT_OVR      = 5;
  localparam int STAT_RXIE     = 6;
  localparam int STAT_TXIE     = 7;
  localparam int STAT_CPHA     = 8;
  localparam int STAT_CPOL     = 9;
  localparam int STAT_DIV_LSB  = 10;

  localparam int         DIV_W   = 6;
  localparam logic [5:0] DIV_RST = 6'd3;

  // Bit order matches ctrl[15:8] so a write can be cast straight into it.
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             cpol;
    logic             cpha;
  } mode_t;

  localparam mode_t MODE_RST = '{div: DIV_RST, cpol: 1'b0, cpha: 1'b0};

  function automatic logic [15:0] pack_status(
    input mode_t m,
    input logic  txie,
    input logic  rxie,
    input logic  ovr,
    input logic  rx_full,
    input logic  rx_empty,
    input logic  tx_full,
    input logic  tx_empty,
    input logic  busy
  );
    pack_status = {m, txie, rxie, ovr, rx_full, rx_empty, tx_full, tx_empty, busy};
  endfunction

endpackage

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: byte-wide synchronous FIFO, head visible combinationally on rd_dat.
// Latency: a pushed byte is at the head one clk after the push.
// Backpressure: push while full is dropped unless a pop happens in the same clk; pop while empty is ignored.
// Ports: clk/rst (sync, active high); push/wr_dat write side; pop/rd_dat read side;
//        full/empty/count occupancy.
module spi_master_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wr_dat,
  input  logic          pop,
  output logic [7:0]    rd_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same clk frees the slot being written, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign rd_dat  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: register-bus SPI master with byte TX/RX FIFOs, programmable DIV and CPOL/CPHA.
// Latency: bus ack 1 clk after cyc; a queued TX byte is popped on the next clk and o_CSn falls 1 clk later.
// Backpressure: none on the bus; TX writes when full are dropped, RX bytes arriving when full are dropped and set OVR.
// Ports: clk/rst (sync, active high); i_dbus_adr/cyc/we/dat, o_dbus_rdt/ack register bus
//        (adr 0 = data FIFO, 1 = control/status); o_int level interrupt; o_SCLK/o_MOSI/i_MISO/o_CSn SPI pins.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_dbus_adr,
  input  logic        i_dbus_cyc,
  input  logic        i_dbus_we,
  input  logic [15:0] i_dbus_dat,
  output logic [15:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_int,
  output logic        o_SCLK,
  output logic        o_MOSI,
  input  logic        i_MISO,
  output logic        o_CSn
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Register-bus state
  mode_t mode_reg;     // programmed DIV/CPOL/CPHA
  logic  txie;
  logic  rxie;
  logic  ovr;

  // Transfer state
  logic [1:0]  state;
  mode_t       mode_lat;  // settings frozen for the byte in flight
  logic [5:0]  div_cnt;
  logic [3:0]  hp;        // half-period index within XFER
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;

  // FIFO hookup
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;

  logic        wr_data, rd_data, wr_ctrl;
  logic        busy;
  logic        half_done;
  logic        xfer_end;
  logic        edge_sample;
  logic        rx_ovf;
  logic [15:0] status;

  // ---------------------------------------------------------------- bus decode
  // Side effects are qualified by ack so each bus cycle acts exactly once.
  assign wr_data = o_dbus_ack &  i_dbus_we & ~i_dbus_adr;
  assign wr_ctrl = o_dbus_ack &  i_dbus_we &  i_dbus_adr;
  assign rd_data = o_dbus_ack & ~i_dbus_we & ~i_dbus_adr;

  assign busy   = (state != ST_IDLE);
  assign status = pack_status(mode_reg, txie, rxie, ovr, rx_full, rx_empty, tx_full, tx_empty, busy);

  always_comb begin
    o_dbus_rdt = '0;
    if (o_dbus_ack && !i_dbus_we) begin
      if (i_dbus_adr)     o_dbus_rdt = status;
      else if (!rx_empty) o_dbus_rdt = {8'd0, rx_head};
    end
  end

  assign o_int = (txie & status[STAT_TX_EMPTY] & ~status[STAT_BUSY])
               | (rxie & ~status[STAT_RX_EMPTY])
               | status[STAT_OVR];

  always_ff @(posedge clk) begin
    if (rst) begin
      o_dbus_ack <= 1'b0;
      mode_reg   <= MODE_RST;
      txie       <= 1'b0;
      rxie       <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      o_dbus_ack <= i_dbus_cyc & ~o_dbus_ack;
      if (wr_ctrl) begin
        mode_reg <= mode_t'(i_dbus_dat[15:STAT_CPHA]);
        txie     <= i_dbus_dat[STAT_TXIE];
        rxie     <= i_dbus_dat[STAT_RXIE];
      end
      // A new overflow wins over a simultaneous clear so the event is never lost.
      if (rx_ovf)                             ovr <= 1'b1;
      else if (wr_ctrl && i_dbus_dat[STAT_OVR]) ovr <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- FIFOs
  assign tx_push = wr_data;
  assign rx_pop  = rd_data;

  assign half_done = (div_cnt == mode_lat.div);
  assign xfer_end  = (state == ST_XFER) & half_done & (hp == 4'd15);
  // Pop either to start from IDLE or to chain the next byte of a burst.
  assign tx_pop    = ~tx_empty & ((state == ST_IDLE) | xfer_end);
  assign rx_push   = xfer_end;
  // A same-clk bus read frees a slot, so that case is not an overflow.
  assign rx_ovf    = xfer_end & rx_full & ~rx_pop;

  spi_master_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_tx_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (tx_push),
    .wr_dat (i_dbus_dat[7:0]),
    .pop    (tx_pop),
    .rd_dat (tx_head),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  spi_master_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_rx_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (rx_push),
    .wr_dat (rx_sh),
    .pop    (rx_pop),
    .rd_dat (rx_head),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  // The occupancy counts must agree with the flags the FSM and bus rely on.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (tx_full  == (tx_count == CW'(FIFO_DEPTH)));
      assert (rx_empty == (rx_count == '0));
    end
  end

  // ---------------------------------------------------------------- FSM
  // Entering XFER half-period hp+1 is SCLK edge number hp+2, which is odd when hp is odd.
  // CPHA=0 samples on odd edges, CPHA=1 on even edges; every other edge shifts MOSI.
  assign edge_sample = hp[0] ^ mode_lat.cpha;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_lat <= MODE_RST;
      div_cnt  <= '0;
      hp       <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      o_SCLK   <= 1'b0;
      o_MOSI   <= 1'b0;
      o_CSn    <= 1'b1;
    end else if (tx_pop) begin
      // Start of a byte, from IDLE or as the next byte of a burst.
      state    <= ST_LEAD;
      mode_lat <= mode_reg;
      div_cnt  <= '0;
      tx_sh    <= tx_head;
      o_MOSI   <= tx_head[7];
      o_SCLK   <= mode_reg.cpol;
      o_CSn    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
        end
        ST_LEAD: begin
          if (half_done) begin
            // Edge 1: CPHA=0 samples here; for CPHA=1 the "shift" is bit 7, already on MOSI.
            state   <= ST_XFER;
            hp      <= '0;
            div_cnt <= '0;
            o_SCLK  <= ~mode_lat.cpol;
            if (!mode_lat.cpha) rx_sh <= {rx_sh[6:0], i_MISO};
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (half_done) begin
            div_cnt <= '0;
            if (hp == 4'd15) begin
              // SCLK is already back at CPOL during the last half-period.
              state  <= ST_TRAIL;
              o_SCLK <= mode_lat.cpol;
            end else begin
              hp     <= hp + 1'b1;
              o_SCLK <= ~o_SCLK;
              if (edge_sample) begin
                rx_sh <= {rx_sh[6:0], i_MISO};
              end else begin
                tx_sh  <= {tx_sh[6:0], 1'b0};
                o_MOSI <= tx_sh[6];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin  // ST_TRAIL
          if (half_done) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            o_CSn   <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
